// File: rtl/imem_loader.sv
// imem_loader: receives a program frame over a byte stream and writes it
// into a 256 x 16 instruction memory while holding the CPU in reset.
// Frame: 0xA5, N (1..255), N words (high byte, then low byte) and,
// when IMEM_LOADER_CHECKSUM_EN is defined, a trailing XOR checksum byte.
// Byte handshake: a byte transfers on a rising clk edge where
// rx_valid and rx_ready are both 1; rx_data is ignored otherwise.
// dbg_state exposes the FSM state for observation.
module imem_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        im_we,
  output logic [7:0]  im_addr,
  output logic [15:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  index_q, index_d;
  logic [15:0] wdata_q, wdata_d;
  logic        accept;
  logic        last_word;

  assign accept    = rx_valid & rx_ready;
  // Widened compare so index+1 never wraps for N = 255.
  assign last_word = (({1'b0, index_q} + 9'd1) >= {1'b0, count_q});

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start only matters in DONE and ERR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && rx_data == 8'hA5) state_d = S_COUNT;
      S_COUNT: if (accept) state_d = (rx_data == 8'h00) ? S_ERR : S_HI;
      S_HI:    if (accept) state_d = S_LO;
      S_LO:    if (accept) state_d = S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_WRITE: state_d = last_word ? S_CSUM : S_HI;
      S_CSUM:  if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
`else
      S_WRITE: state_d = last_word ? S_DONE : S_HI;
`endif
      S_DONE:  if (start) state_d = S_IDLE;
      S_ERR:   if (start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; rx_ready is forced low while reset is held.
  always_comb begin
    rx_ready  = 1'b0;
    im_we     = 1'b0;
    cpu_hold  = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    dbg_state = state_q;
    case (state_q)
      S_IDLE, S_COUNT, S_HI, S_LO, S_CSUM: rx_ready = reset;
      S_WRITE: im_we = 1'b1;
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: word count, write index, assembled word, checksum.
  always_comb begin
    count_d = count_q;
    index_d = index_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_IDLE:  if (accept && rx_data == 8'hA5) csum_d = 8'h00;
`endif
      S_COUNT: if (accept && rx_data != 8'h00) begin
        count_d = rx_data;
        index_d = 8'h00;
      end
      S_HI: if (accept) begin
        wdata_d[15:8] = rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d = csum_q ^ rx_data;
`endif
      end
      S_LO: if (accept) begin
        wdata_d[7:0] = rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d = csum_q ^ rx_data;
`endif
      end
      S_WRITE: index_d = index_q + 8'd1;
      S_DONE, S_ERR: if (start) index_d = 8'h00;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 8'h00;
      index_q <= 8'h00;
      wdata_q <= 16'h0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      count_q <= count_d;
      index_q <= index_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign im_addr  = index_q;
  assign im_wdata = wdata_q;

endmodule
